led_data_rx: RTL and testbench

LED_DATA_RX -- requirements
Module: led_data_rx

---
 rtl/led_data_rx.sv | 73 +++++++
 tb/tb_led_data_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/led_data_rx.sv
// led_data_rx: serial LED pixel receiver assembling words into a double-buffered frame store
module led_data_rx #(
  parameter int DW = 16,
  parameter int NPIX = 256,
  localparam int AW = $clog2(NPIX)
) (
  input  logic          DCK,
  input  logic          rst_n,
  input  logic          DAI,
  input  logic          DEN,
  input  logic          frame_ack,
  output logic          wr_en,
  output logic [AW:0]   wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          frame_done,
  output logic          frame_rdy,
  output logic          rd_bank,
  output logic          ovf,
  output logic          frag_err
);
  localparam int BW = $clog2(DW);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t        state, state_nx;
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] shreg;
  logic [AW-1:0] word_cnt;
  logic          wr_bank;
  logic          word_end, frame_end;
  // a word ends on its DW-th sampled bit; the frame ends with the last word of the frame
  always_comb begin
    word_end  = state == SHIFT && DEN && bit_cnt == BW'(DW - 1);
    frame_end = word_end && word_cnt == AW'(NPIX - 1);
    state_nx  = DEN && !word_end ? SHIFT : IDLE;
  end
  // state register
  always_ff @(posedge DCK or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // bit assembly, word/bank bookkeeping and registered outputs
  always_ff @(posedge DCK or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b1;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_rdy  <= 1'b0;
      ovf        <= 1'b0;
      frag_err   <= 1'b0;
    end else begin
      shreg      <= DEN ? {shreg[DW-2:0], DAI} : '0;
      bit_cnt    <= DEN && !word_end ? bit_cnt + 1'b1 : '0;
      wr_en      <= word_end;
      frame_done <= frame_end;
      ovf        <= frame_end && frame_rdy && !frame_ack;
      frag_err   <= state == SHIFT && !DEN;
      frame_rdy  <= frame_end ? 1'b1 : frame_ack ? 1'b0 : frame_rdy;
      if (word_end) begin
        wr_data  <= {shreg[DW-2:0], DAI};
        wr_addr  <= {wr_bank, word_cnt};
        word_cnt <= frame_end ? '0 : word_cnt + 1'b1;
      end
      if (frame_done && !ovf) begin
        wr_bank <= ~wr_bank;
        rd_bank <= wr_bank;
      end
    end
  end
endmodule

// File: tb/tb_led_data_rx.sv
// tb_led_data_rx: randomized bench comparing led_data_rx against a queue-based frame model
module tb_led_data_rx;
  localparam int DW = 16;
  localparam int NPIX = 256;
  logic DCK = 1'b0, rst_n = 1'b0, DAI = 1'b0, DEN = 1'b0, frame_ack = 1'b0;
  logic wr_en, frame_done, frame_rdy, rd_bank, ovf, frag_err;
  logic [8:0] wr_addr;
  logic [15:0] wr_data;
  int checks = 0, errors = 0;
  bit q[$];
  int wcnt;
  bit bank, pend, m_rdy, completed;
  logic e_wr_en, e_done, e_ovf, e_frag, e_rd_bank;
  logic [8:0] e_addr;
  logic [15:0] e_data;

  always #5 DCK = ~DCK;

  led_data_rx #(.DW(DW), .NPIX(NPIX)) dut (
    .DCK(DCK), .rst_n(rst_n), .DAI(DAI), .DEN(DEN), .frame_ack(frame_ack),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
    .frame_rdy(frame_rdy), .rd_bank(rd_bank), .ovf(ovf), .frag_err(frag_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: bits collect in a queue, a full queue becomes one write
  initial forever begin
    @(posedge DCK or negedge rst_n);
    if (!rst_n) begin
      q.delete(); wcnt = 0; bank = 0; pend = 0; m_rdy = 0;
      e_wr_en = 0; e_done = 0; e_ovf = 0; e_frag = 0; e_addr = 0; e_data = 0; e_rd_bank = 1;
    end else begin
      completed = 0;
      e_wr_en = 0; e_done = 0; e_ovf = 0; e_frag = 0;
      if (pend) begin bank = !bank; pend = 0; end
      if (!DEN) begin
        if (q.size() > 0) e_frag = 1;
        q.delete();
      end else begin
        q.push_back(DAI);
        if (q.size() == DW) begin
          e_data = 0;
          foreach (q[i]) e_data = (e_data << 1) | 16'(q[i]);
          q.delete();
          e_wr_en = 1;
          e_addr = 9'(bank * NPIX + wcnt);
          if (wcnt == NPIX - 1) begin
            completed = 1;
            e_done = 1;
            if (m_rdy && !frame_ack) e_ovf = 1; else pend = 1;
            m_rdy = 1;
          end
          wcnt = (wcnt + 1) % NPIX;
        end
      end
      if (!completed && frame_ack) m_rdy = 0;
      e_rd_bank = !bank;
    end
  end

  initial forever begin
    @(negedge DCK);
    if (rst_n === 1'b1) begin
      chk("wr_en", wr_en, e_wr_en);
      chk("wr_addr", wr_addr, e_addr);
      chk("wr_data", wr_data, e_data);
      chk("frame_done", frame_done, e_done);
      chk("frame_rdy", frame_rdy, m_rdy);
      chk("rd_bank", rd_bank, e_rd_bank);
      chk("ovf", ovf, e_ovf);
      chk("frag_err", frag_err, e_frag);
    end
  end

  task automatic send_bits(input logic [15:0] w, input int n, input bit ack_last);
    for (int i = DW - 1; i >= DW - n; i--) begin
      @(negedge DCK);
      DEN = 1'b1;
      DAI = w[i];
      frame_ack = ack_last && i == 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge DCK);
      DEN = 1'b0;
      DAI = 1'($urandom);
      frame_ack = ($urandom % 8) == 0;
    end
  endtask

  task automatic settle();
    @(negedge DCK);
    DEN = 1'b0;
    frame_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge DCK);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_bank", rd_bank, 1);
    chk("rst_addr", wr_addr, 0);
    rst_n = 1'b1;
    @(negedge DCK);
    send_bits(16'hA5C3, 16, 0);
    settle();
    chk("w0_en", wr_en, 1);
    chk("w0_data", wr_data, 16'hA5C3);
    chk("w0_addr", wr_addr, 9'h000);
    send_bits(16'($urandom), 9, 0);
    settle();
    @(negedge DCK);
    chk("frag_pulse", frag_err, 1);
    chk("frag_no_wr", wr_en, 0);
    send_bits(16'h1234, 16, 0);
    settle();
    chk("after_frag_addr", wr_addr, 9'h001);
    chk("after_frag_data", wr_data, 16'h1234);
    for (int k = 2; k < NPIX; k++) send_bits(16'($urandom), 16, 0);
    settle();
    chk("f1_done", frame_done, 1);
    chk("f1_rdy", frame_rdy, 1);
    chk("f1_addr", wr_addr, 9'h0FF);
    @(negedge DCK);
    chk("f1_rd_bank", rd_bank, 0);
    for (int k = 0; k < NPIX; k++) send_bits(16'($urandom), 16, 0);
    settle();
    chk("f2_ovf", ovf, 1);
    chk("f2_addr", wr_addr, 9'h1FF);
    @(negedge DCK);
    chk("f2_rd_bank", rd_bank, 0);
    send_bits(16'($urandom), 16, 0);
    settle();
    chk("f3_first_addr", wr_addr, 9'h100);
    for (int k = 1; k < NPIX - 1; k++) send_bits(16'($urandom), 16, 0);
    send_bits(16'($urandom), 16, 1);
    settle();
    chk("f3_no_ovf", ovf, 0);
    chk("f3_done", frame_done, 1);
    chk("f3_rdy", frame_rdy, 1);
    @(negedge DCK);
    chk("f3_rd_bank", rd_bank, 1);
    @(negedge DCK); frame_ack = 1'b1;
    @(negedge DCK); frame_ack = 1'b0;
    chk("ack_clears", frame_rdy, 0);
    repeat (300) begin
      if ($urandom % 8 == 0) begin
        send_bits(16'($urandom), $urandom_range(1, 15), 0);
        idle($urandom_range(1, 2));
      end else begin
        send_bits(16'($urandom), 16, 0);
        if ($urandom % 3 == 0) idle($urandom_range(1, 3));
      end
    end
    idle(2);
    settle();
    #2 rst_n = 1'b0;
    @(negedge DCK); rst_n = 1'b1;
    for (int k = 0; k < 100; k++) send_bits(16'($urandom), 16, 0);
    send_bits(16'($urandom), 7, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", wr_addr, 0);
    chk("mid_rst_data", wr_data, 0);
    chk("mid_rst_rd_bank", rd_bank, 1);
    chk("mid_rst_wr_en", wr_en, 0);
    settle();
    @(negedge DCK); rst_n = 1'b1;
    send_bits(16'hBEEF, 16, 0);
    settle();
    chk("post_rst_en", wr_en, 1);
    chk("post_rst_addr", wr_addr, 9'h000);
    chk("post_rst_data", wr_data, 16'hBEEF);
    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
